// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter
// Round-robin scheduler in front of a UART transmitter that has no busy flag.
// Each winning byte is presented on tx_data with a one-cycle tx_start pulse.
// The block then counts out a full frame plus guard time before it will issue
// another grant.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 5208,
    parameter int FRAME_BITS   = 10,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    output logic                 busy
);

    localparam int FRAME_CYCLES = CLKS_PER_BIT * FRAME_BITS + GUARD_CYCLES;
    localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
    localparam int PTR_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_nextState;
    logic [PTR_W-1:0]     r_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic [NUM_REQ-1:0]   r_gntVec;
    logic [7:0]           r_txData;

    logic                 w_found;
    logic                 w_foundHi;
    logic [PTR_W-1:0]     w_winHi;
    logic [PTR_W-1:0]     w_winAny;
    logic [PTR_W-1:0]     w_win;
    logic [PTR_W-1:0]     w_nextPtr;
    logic [NUM_REQ-1:0]   w_winOneHot;
    logic [7:0]           w_selData;
    logic                 w_take;

    // Round-robin search: the lowest requester at or above ptr wins; if none,
    // wrap around and take the lowest requester overall.
    always_comb begin
        w_found   = 1'b0;
        w_foundHi = 1'b0;
        w_winHi   = '0;
        w_winAny  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_found  = 1'b1;
                w_winAny = PTR_W'(i);
                if (PTR_W'(i) >= r_ptr) begin
                    w_foundHi = 1'b1;
                    w_winHi   = PTR_W'(i);
                end
            end
        end
        w_win     = w_foundHi ? w_winHi : w_winAny;
        w_nextPtr = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
    end

    // Only the winner's byte lane is steered toward the data register.
    always_comb begin
        w_selData   = 8'h00;
        w_winOneHot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_selData      = req_data[8*i +: 8];
                w_winOneHot[i] = 1'b1;
            end
        end
    end

    // State register; reset drops straight back to IDLE so the outputs clear
    // without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: grant from IDLE, one START cycle, then time the frame.
    always_comb begin
        w_nextState = r_state;
        w_take      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && w_found) begin
                    w_take      = 1'b1;
                    w_nextState = START;
                end
            end
            START: begin
                w_nextState = WAIT;
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: capture the winner's byte and grant at decision time, advance
    // the pointer, and run the frame timer (load in START, count down in WAIT).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_gntVec <= '0;
            r_txData <= 8'h00;
        end else begin
            if (w_take) begin
                r_txData <= w_selData;
                r_gntVec <= w_winOneHot;
                r_ptr    <= w_nextPtr;
            end
            if (r_state == START) begin
                r_cnt <= CNT_W'(FRAME_CYCLES - 1);
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign gnt      = (r_state == START) ? r_gntVec : '0;
    assign tx_start = (r_state == START);
    assign busy     = (r_state != IDLE);
    assign tx_data  = r_txData;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Testbench for uart_tx_arbiter: directed steps with a grant scoreboard.
// Expected grants (requester, byte) are queued as stimulus is applied and
// popped whenever the DUT raises gnt.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int CPB          = 4;
    localparam int FB           = 10;
    localparam int GUARD        = 2;
    localparam int FRAME_CYCLES = CPB * FB + GUARD;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        enable  = 1'b0;
    logic [3:0]  req     = 4'b0000;
    logic [31:0] reqData = 32'h0;
    logic [3:0]  gnt;
    logic [7:0]  txData;
    logic        txStart;
    logic        busy;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } grant_t;

    grant_t     sbq[$];
    int         total     = 0;
    int         bad       = 0;
    int         cyc       = 0;
    int         lastStart = -1;
    logic [7:0] curData   = 8'h00;
    bit         autoDrop  = 1'b0;
    bit         spacingOn = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .CLKS_PER_BIT (CPB),
        .FRAME_BITS   (FB),
        .GUARD_CYCLES (GUARD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .req      (req),
        .req_data (reqData),
        .gnt      (gnt),
        .tx_data  (txData),
        .tx_start (txStart),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic pushExp(input int idx, input logic [7:0] data);
        grant_t e;
        e.idx  = idx;
        e.data = data;
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] mask, input logic [31:0] data);
        req     = mask;
        reqData = data;
    endtask

    // One clock: sample at the falling edge, score any grant, check that
    // tx_data holds between grants and that tx_start only rides with gnt.
    task automatic tick();
        grant_t e;
        @(negedge clk);
        cyc++;
        if (gnt !== 4'b0000) begin
            checkOutput("gntOneHot", 32'($onehot(gnt)), 32'd1);
            if (sbq.size() == 0) begin
                checkOutput("unexpectedGnt", 32'(gnt), 32'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("gntWinner", 32'(gnt), 32'd1 << e.idx);
                checkOutput("txDataAtGnt", 32'(txData), 32'(e.data));
                checkOutput("txStartWithGnt", 32'(txStart), 32'd1);
                curData = e.data;
            end
            if (autoDrop) req = req & ~gnt;
        end else begin
            checkOutput("txStartNoGnt", 32'(txStart), 32'd0);
            checkOutput("txDataHold", 32'(txData), 32'(curData));
        end
        if (txStart === 1'b1) begin
            if (spacingOn && lastStart >= 0)
                checkOutput("startSpacing", 32'(cyc - lastStart), 32'(FRAME_CYCLES + 2));
            lastStart = cyc;
        end
    endtask

    task automatic runUntilDrained(input string tag, input int limit);
        int n = 0;
        while (sbq.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput({tag, "Drained"}, 32'(sbq.size()), 32'd0);
        sbq.delete();
    endtask

    task automatic waitIdle(input string tag, input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
        checkOutput({tag, "Idle"}, 32'(busy), 32'd0);
    endtask

    // Called on the START cycle; counts cycles with busy high, optionally
    // dropping enable partway through the frame.
    task automatic measureBusy(input string tag, input int dropEnableAt);
        int n = (busy === 1'b1) ? 1 : 0;
        while (n < 200) begin
            if (n == dropEnableAt) enable = 1'b0;
            tick();
            if (busy === 1'b1) n++;
            else break;
        end
        checkOutput({tag, "BusyLen"}, 32'(n), 32'(FRAME_CYCLES + 1));
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset     = 1'b1;
        req       = 4'b0000;
        enable    = 1'b0;
        autoDrop  = 1'b0;
        spacingOn = 1'b0;
        lastStart = -1;
        curData   = 8'h00;
        sbq.delete();
        repeat (2) tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstGnt", 32'(gnt), 32'd0);
        checkOutput("rstTxStart", 32'(txStart), 32'd0);
        checkOutput("rstTxData", 32'(txData), 32'h00);
        reset = 1'b0;
        repeat (2) tick();

        // Single request
        $display("[TB] single request");
        enable   = 1'b1;
        autoDrop = 1'b1;
        applyStimulus(4'b0100, 32'h00A5_0000);
        pushExp(2, 8'hA5);
        tick();
        checkOutput("t1BusyAtStart", 32'(busy), 32'd1);
        measureBusy("t1", -1);
        runUntilDrained("t1", 1);
        repeat (3) tick();

        // All requesters at once
        $display("[TB] all requesters");
        applyReset();
        enable    = 1'b1;
        autoDrop  = 1'b1;
        spacingOn = 1'b1;
        applyStimulus(4'b1111, 32'h1312_1110);
        for (int i = 0; i < 4; i++) pushExp(i, 8'h10 + 8'(i));
        runUntilDrained("t2", 4 * 50);
        waitIdle("t2", 60);
        spacingOn = 1'b0;

        // Fairness between two permanent requesters
        $display("[TB] fairness");
        applyReset();
        enable   = 1'b1;
        autoDrop = 1'b0;
        applyStimulus(4'b0101, 32'h0032_0030);
        for (int i = 0; i < 3; i++) begin
            pushExp(0, 8'h30);
            pushExp(2, 8'h32);
        end
        runUntilDrained("t3", 6 * 50);
        req = 4'b0000;
        waitIdle("t3", 60);
        repeat (3) tick();

        // Enable gating
        $display("[TB] enable gating");
        applyReset();
        enable = 1'b0;
        applyStimulus(4'b0001, 32'h0000_0044);
        repeat (100) begin
            tick();
            checkOutput("t4Gated", 32'(busy), 32'd0);
        end
        enable   = 1'b1;
        autoDrop = 1'b1;
        pushExp(0, 8'h44);
        tick();
        checkOutput("t4BusyAtStart", 32'(busy), 32'd1);
        measureBusy("t4", 10);
        runUntilDrained("t4", 1);

        // Reset in the middle of WAIT; grant to 0 leaves ptr at 1, so a
        // retained pointer would pick requester 1 first afterwards
        $display("[TB] reset mid-wait");
        applyReset();
        enable   = 1'b1;
        autoDrop = 1'b1;
        applyStimulus(4'b0001, 32'h0000_0055);
        pushExp(0, 8'h55);
        tick();
        repeat (10) tick();
        checkOutput("t5BusyBefore", 32'(busy), 32'd1);
        reset   = 1'b1;
        curData = 8'h00;
        #1;
        checkOutput("t5AsyncBusy", 32'(busy), 32'd0);
        checkOutput("t5AsyncGnt", 32'(gnt), 32'd0);
        checkOutput("t5AsyncTxStart", 32'(txStart), 32'd0);
        checkOutput("t5AsyncTxData", 32'(txData), 32'h00);
        repeat (2) tick();
        reset = 1'b0;
        applyStimulus(4'b0011, 32'h0000_6261);
        pushExp(0, 8'h61);
        pushExp(1, 8'h62);
        runUntilDrained("t5", 120);
        waitIdle("t5", 60);

        // Withdrawn request is skipped
        $display("[TB] withdrawn request");
        applyReset();
        enable   = 1'b1;
        autoDrop = 1'b1;
        applyStimulus(4'b1011, 32'hD300_D1D0);
        pushExp(0, 8'hD0);
        tick();
        repeat (5) tick();
        req[1] = 1'b0;
        pushExp(3, 8'hD3);
        runUntilDrained("t6", 120);
        waitIdle("t6", 60);
        repeat (50) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
